// File: rtl/iir_cfg_ctrl.sv
// iir_cfg_ctrl: shadow/active coefficient registers and drain-swap-clear sequencing around iir_2nd_order.
// Define DROP_CNT_EN to add the saturating drop_cnt output (dropped source samples).
module iir_cfg_ctrl #(
    parameter int NB      = 12,
    parameter int LAT     = 2,
    parameter int CLR_CYC = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  logic [NB-1:0] cfg_data,
    input  logic          cfg_commit,
    output logic          cfg_busy,
    input  logic          vin_s,
    input  logic [NB-1:0] din_s,
    output logic          rdy,
    output logic          vin,
    output logic [NB-1:0] din,
    output logic          filt_rst_n,
    output logic [NB-1:0] b0,
    output logic [NB-1:0] b1,
    output logic [NB-1:0] b2,
    output logic [NB-1:0] a1,
    output logic [NB-1:0] a2,
    input  logic          vout_f,
    input  logic [NB-1:0] dout_f,
    output logic          vout,
    output logic [NB-1:0] dout
`ifdef DROP_CNT_EN
    ,
    output logic [15:0]   drop_cnt
`endif
);

    localparam int CNT_MAX = ((LAT + 1) > CLR_CYC) ? (LAT + 1) : CLR_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DRAIN_LD = CW'(LAT + 1);
    localparam logic [CW-1:0] CLEAR_LD = CW'(CLR_CYC);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_APPLY = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [CW-1:0]   cnt_r;
    logic            rdy_s, busy_s, pass_s, accept_s;
    logic            clr_n_r, vin_r;
    logic [NB-1:0]   din_r;
    logic [NB-1:0]   shd_b0_r, shd_b1_r, shd_b2_r, shd_a1_r, shd_a2_r;
    logic [NB-1:0]   act_b0_r, act_b1_r, act_b2_r, act_a1_r, act_a2_r;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_s;
    end

    // next-state logic; DRAIN/CLEAR leave on the edge that takes the counter to zero
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  if (cfg_commit) state_s = ST_APPLY; else state_s = ST_IDLE;
            ST_RUN:   if (cfg_commit) state_s = ST_DRAIN; else state_s = ST_RUN;
            ST_DRAIN: if (cnt_r == CNT_ONE) state_s = ST_APPLY; else state_s = ST_DRAIN;
            ST_APPLY: state_s = ST_CLEAR;
            ST_CLEAR: if (cnt_r == CNT_ONE) state_s = ST_RUN; else state_s = ST_CLEAR;
            default:  state_s = ST_IDLE;
        endcase
    end

    // state-decoded handshake and gating
    always_comb begin
        rdy_s  = 1'b0;
        busy_s = 1'b0;
        pass_s = 1'b0;
        case (state_r)
            ST_RUN:   begin rdy_s = 1'b1; pass_s = 1'b1; end
            ST_DRAIN: begin busy_s = 1'b1; pass_s = 1'b1; end
            ST_APPLY: busy_s = 1'b1;
            ST_CLEAR: busy_s = 1'b1;
            default:  busy_s = 1'b0;
        endcase
    end

    // shared DRAIN/CLEAR cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else begin
            case (state_r)
                ST_RUN:   if (cfg_commit) cnt_r <= DRAIN_LD; else cnt_r <= cnt_r;
                ST_DRAIN: cnt_r <= cnt_r - CNT_ONE;
                ST_APPLY: cnt_r <= CLEAR_LD;
                ST_CLEAR: cnt_r <= cnt_r - CNT_ONE;
                default:  cnt_r <= cnt_r;
            endcase
        end
    end

    // filter local reset, low exactly while in CLEAR
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clr_n_r <= 1'b1;
        else        clr_n_r <= (state_s != ST_CLEAR);
    end

    // shadow coefficient writes, accepted in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shd_b0_r <= '0; shd_b1_r <= '0; shd_b2_r <= '0; shd_a1_r <= '0; shd_a2_r <= '0;
        end else if (cfg_we) begin
            case (cfg_addr)
                3'd0:    shd_b0_r <= cfg_data;
                3'd1:    shd_b1_r <= cfg_data;
                3'd2:    shd_b2_r <= cfg_data;
                3'd3:    shd_a1_r <= cfg_data;
                3'd4:    shd_a2_r <= cfg_data;
                default: shd_b0_r <= shd_b0_r;
            endcase
        end
    end

    // atomic swap at the end of APPLY; a same-edge shadow write misses this copy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_b0_r <= '0; act_b1_r <= '0; act_b2_r <= '0; act_a1_r <= '0; act_a2_r <= '0;
        end else if (state_r == ST_APPLY) begin
            act_b0_r <= shd_b0_r; act_b1_r <= shd_b1_r; act_b2_r <= shd_b2_r;
            act_a1_r <= shd_a1_r; act_a2_r <= shd_a2_r;
        end
    end

    assign accept_s = vin_s & rdy_s;

    // one-cycle input register toward the filter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vin_r <= 1'b0;
            din_r <= '0;
        end else begin
            vin_r <= accept_s;
            if (accept_s) din_r <= din_s;
        end
    end

`ifdef DROP_CNT_EN
    logic [15:0] drop_cnt_r;

    // saturating count of samples offered while not ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                       drop_cnt_r <= 16'd0;
        else if (vin_s && !rdy_s && drop_cnt_r != 16'hFFFF) drop_cnt_r <= drop_cnt_r + 16'd1;
    end

    assign drop_cnt = drop_cnt_r;
`endif

    assign rdy        = rdy_s;
    assign cfg_busy   = busy_s;
    assign vin        = vin_r;
    assign din        = din_r;
    assign filt_rst_n = rst_n & clr_n_r;
    assign b0         = act_b0_r;
    assign b1         = act_b1_r;
    assign b2         = act_b2_r;
    assign a1         = act_a1_r;
    assign a2         = act_a2_r;
    assign vout       = vout_f & pass_s;
    assign dout       = dout_f;

endmodule

// File: tb/tb_iir_cfg_ctrl.sv
// Self-checking bench for iir_cfg_ctrl with a LAT-cycle pass-through filter stand-in and output scoreboard.
module tb_iir_cfg_ctrl;

    localparam int NB      = 12;
    localparam int LAT     = 2;
    localparam int CLR_CYC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_we = 1'b0;
    logic [2:0]    cfg_addr = 3'd0;
    logic [NB-1:0] cfg_data = '0;
    logic          cfg_commit = 1'b0;
    logic          cfg_busy;
    logic          vin_s = 1'b0;
    logic [NB-1:0] din_s = '0;
    logic          rdy, vin, filt_rst_n, vout_f, vout;
    logic [NB-1:0] din, b0, b1, b2, a1, a2, dout_f, dout;
    logic          vout_inj = 1'b0;
`ifdef DROP_CNT_EN
    logic [15:0]   drop_cnt;
`endif

    int total = 0;
    int bad   = 0;
    logic [NB-1:0] sb_q [$];
    logic [NB-1:0] exp_shd [5];
    logic [NB-1:0] exp_act [5];

    iir_cfg_ctrl #(.NB(NB), .LAT(LAT), .CLR_CYC(CLR_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .vin_s(vin_s), .din_s(din_s), .rdy(rdy),
        .vin(vin), .din(din), .filt_rst_n(filt_rst_n), .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2),
        .vout_f(vout_f), .dout_f(dout_f), .vout(vout), .dout(dout)
`ifdef DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // filter stand-in: LAT-stage pass-through cleared by its own reset
    logic          fv0, fv1;
    logic [NB-1:0] fd0, fd1;
    always_ff @(posedge clk or negedge filt_rst_n) begin
        if (!filt_rst_n) begin
            fv0 <= 1'b0; fv1 <= 1'b0; fd0 <= '0; fd1 <= '0;
        end else begin
            fv0 <= vin; fv1 <= fv0; fd0 <= din; fd1 <= fd0;
        end
    end
    assign vout_f = fv1 | vout_inj;
    assign dout_f = fd1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every sink output must match the oldest accepted sample
    always @(negedge clk) begin
        if (rst_n && vout) begin
            if (sb_q.size() == 0) begin
                check_val("vout_spurious", 32'(vout), 32'd0);
            end else begin
                logic [NB-1:0] e;
                e = sb_q.pop_front();
                check_val("dout", 32'(dout), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
    endtask

    task automatic src(input logic v, input logic [NB-1:0] d, input bit acc);
        vin_s = v;
        din_s = d;
        if (v && acc) sb_q.push_back(d);
    endtask

    task automatic wr(input logic [2:0] a, input logic [NB-1:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        if (int'(a) < 5) exp_shd[int'(a)] = d;
    endtask

    task automatic chk_ctl(input string tag, input logic r, input logic b, input logic f);
        check_val({tag, "_rdy"}, 32'(rdy), 32'(r));
        check_val({tag, "_busy"}, 32'(cfg_busy), 32'(b));
        check_val({tag, "_frst"}, 32'(filt_rst_n), 32'(f));
    endtask

    task automatic chk_coef(input string tag);
        check_val({tag, "_b0"}, 32'(b0), 32'(exp_act[0]));
        check_val({tag, "_b1"}, 32'(b1), 32'(exp_act[1]));
        check_val({tag, "_b2"}, 32'(b2), 32'(exp_act[2]));
        check_val({tag, "_a1"}, 32'(a1), 32'(exp_act[3]));
        check_val({tag, "_a2"}, 32'(a2), 32'(exp_act[4]));
    endtask

    task automatic gate_chk(input string tag);
        vout_inj = 1'b1;
        #1;
        check_val(tag, 32'(vout), 32'd0);
        vout_inj = 1'b0;
    endtask

    // commit pulse plus cycle-by-cycle walk of the whole busy sequence
    task automatic seq_commit(input bit from_run, input bit hold, input bit drain_cmt,
                              input bit drain_wr, input bit apply_wr);
        logic [NB-1:0] snap [5];
        cfg_commit = 1'b1;
        tick();
        if (from_run) begin
            for (int i = 0; i < LAT + 1; i++) begin
                chk_ctl("drain", 1'b0, 1'b1, 1'b1);
                chk_coef("drain");
                if (hold) src(1'b1, din_s + 12'd1, 1'b0);
                if (drain_cmt && i == 0) cfg_commit = 1'b1;
                if (drain_wr && i == LAT) wr(3'd4, 12'h7FF);
                tick();
            end
        end
        chk_ctl("apply", 1'b0, 1'b1, 1'b1);
        chk_coef("apply");
        gate_chk("gate_apply");
        snap = exp_shd;
        if (hold) src(1'b1, din_s + 12'd1, 1'b0);
        if (apply_wr) wr(3'd2, 12'h321);
        tick();
        exp_act = snap;
        for (int i = 0; i < CLR_CYC; i++) begin
            chk_ctl("clear", 1'b0, 1'b1, 1'b0);
            chk_coef("clear");
            gate_chk("gate_clear");
            if (hold) src(1'b1, din_s + 12'd1, 1'b0);
            tick();
        end
        chk_ctl("run", 1'b1, 1'b0, 1'b1);
        chk_coef("run");
    endtask

    initial begin
        for (int i = 0; i < 5; i++) begin exp_shd[i] = '0; exp_act[i] = '0; end

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk_ctl("rst", 1'b0, 1'b0, 1'b0);
        chk_coef("rst");
        check_val("rst_vin", 32'(vin), 32'd0);
        check_val("rst_din", 32'(din), 32'd0);
        rst_n = 1'b1;
        #1;
        chk_ctl("idle", 1'b0, 1'b0, 1'b1);

        // IDLE drops samples and gates filter output
        src(1'b1, 12'hABC, 1'b0);
        gate_chk("gate_idle");
        tick();
        check_val("idle_vin", 32'(vin), 32'd0);
        src(1'b0, 12'h000, 1'b0);

        // 1: first commit from IDLE; write to an unused address must be ignored
        wr(3'd0, 12'h100);
        tick();
        wr(3'd6, 12'hFFF);
        tick();
        seq_commit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("t1_b0", 32'(b0), 32'h100);

        // 2: impulse then a short stream
        src(1'b1, 12'h200, 1'b1);
        tick();
        check_val("t2_vin1", 32'(vin), 32'd1);
        check_val("t2_din1", 32'(din), 32'h200);
        src(1'b0, 12'h000, 1'b1);
        tick();
        check_val("t2_vin0", 32'(vin), 32'd0);
        check_val("t2_din_hold", 32'(din), 32'h200);
        check_val("t2_vout_early", 32'(vout), 32'd0);
        tick();
        check_val("t2_vout_lat", 32'(vout), 32'd1);
        check_val("t2_dout_lat", 32'(dout), 32'h200);
        for (int i = 0; i < 6; i++) begin
            src(1'b1, 12'(16 + 3 * i), 1'b1);
            tick();
        end

        // 3: mid-stream commit with a write in the commit cycle
        src(1'b1, 12'h055, 1'b1);
        wr(3'd3, 12'hF80);
        seq_commit(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("t3_a1", 32'(a1), 32'hF80);
        src(1'b0, 12'h000, 1'b0);
        repeat (4) tick();

        // 4: ignored commit in DRAIN, write in DRAIN applied, write in APPLY deferred
        src(1'b1, 12'h066, 1'b1);
        seq_commit(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        check_val("t4_b2_deferred", 32'(b2), 32'h000);
        src(1'b0, 12'h000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_ctl("t4_no_requeue", 1'b1, 1'b0, 1'b1);
        end
        seq_commit(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("t4_b2_next", 32'(b2), 32'h321);

        // 5: asynchronous reset in CLEAR
        src(1'b1, 12'h077, 1'b1);
        cfg_commit = 1'b1;
        tick();
        src(1'b0, 12'h000, 1'b0);
        repeat (LAT + 2) tick();
        chk_ctl("t5_clear", 1'b0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        for (int i = 0; i < 5; i++) begin exp_shd[i] = '0; exp_act[i] = '0; end
        #1;
        chk_ctl("t5_rst", 1'b0, 1'b0, 1'b0);
        chk_coef("t5_rst");
        check_val("t5_vin", 32'(vin), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        chk_ctl("t5_idle", 1'b0, 1'b0, 1'b1);

`ifdef DROP_CNT_EN
        // 6: drop counter over one commit sequence, then saturation in IDLE
        check_val("t6_drop0", 32'(drop_cnt), 32'd0);
        seq_commit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        src(1'b1, 12'h0A0, 1'b1);
        seq_commit(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_val("t6_drop_seq", 32'(drop_cnt), 32'(LAT + 2 + CLR_CYC));
        src(1'b0, 12'h000, 1'b0);
        repeat (4) tick();
        rst_n = 1'b0;
        sb_q.delete();
        #2;
        rst_n = 1'b1;
        src(1'b1, 12'h0BB, 1'b0);
        repeat (65534) tick();
        check_val("t6_drop_fffe", 32'(drop_cnt), 32'hFFFE);
        tick();
        check_val("t6_drop_ffff", 32'(drop_cnt), 32'hFFFF);
        repeat (70000 - 65535) tick();
        check_val("t6_drop_sat", 32'(drop_cnt), 32'hFFFF);
        src(1'b0, 12'h000, 1'b0);
`endif

        repeat (5) tick();
        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
